fetch_buffer: RTL and testbench

- Instruction-fetch front end feeding the ID stage of the 5-stage RV32 core.
- Owns the fetch PC and drives the asynchronous instruction memory.
- Queues fetched {pc, ir} pairs in a small FIFO so ID can stall without losing fetches.
- Flushes and re-steers on a taken branch from EX; stops fetching after the halt instruction 32'h000f0033.

---
 rtl/fetch_buffer.sv | 138 +++++++++++++
 tb/tb_fetch_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch front end for the RV32 pipeline.
// Owns the fetch PC, drives the asynchronous imem, and queues {pc, ir}
// pairs so ID can stall without losing fetches. A taken-branch redirect
// flushes the queue and re-steers; fetching stops once the halt word is
// queued, until the next redirect or reset.
// Optional feature: define FETCH_BUF_BYPASS_EN to present the imem word
// on the head outputs in the same cycle while the queue is empty.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 12,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     w_clk,
  input  logic                     w_rst_n,
  input  logic                     w_ce,
  output logic [AW-1:0]            w_imem_addr,
  input  logic [31:0]              w_imem_data,
  input  logic                     w_redir,
  input  logic [31:0]              w_redir_pc,
  input  logic                     w_deq,
  output logic                     w_valid,
  output logic [31:0]              w_pc,
  output logic [31:0]              w_ir,
  output logic                     w_halted,
  output logic [$clog2(DEPTH):0]   w_count
);

  localparam int            PW        = $clog2(DEPTH);
  localparam int            CW        = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [31:0]   NOP_INSN  = 32'h0000_0013;
  localparam logic [31:0]   HALT_INSN = 32'h000f_0033;

  logic [31:0]   r_fpc;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_halted;
  logic [31:0]   r_pc_mem [DEPTH];
  logic [31:0]   r_ir_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_fetch;
  logic w_byp_live;
  logic w_byp_take;
  logic w_push;
  logic w_deq_q;
  logic w_halt_hit;
  logic w_unused_redir_lo;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_imem_addr = r_fpc[AW+1:2];
  assign w_count     = r_count;
  assign w_halted    = r_halted;

  // Low target bits are forced to zero; they carry no information here.
  assign w_unused_redir_lo = ^w_redir_pc[1:0];

  // A fetch consumes the current imem word, whether it lands in the queue
  // or goes straight out through the bypass.
  assign w_fetch    = !r_halted && !w_redir && (!w_full || w_deq);
  assign w_halt_hit = w_fetch && (w_imem_data == HALT_INSN);

`ifdef FETCH_BUF_BYPASS_EN
  assign w_byp_live = w_empty && !r_halted && !w_redir;
`else
  assign w_byp_live = 1'b0;
`endif

  // A bypassed word taken by ID this cycle is never written into the queue.
  assign w_byp_take = w_byp_live && w_deq;
  assign w_push     = w_fetch && !w_byp_take;
  assign w_deq_q    = w_deq && !w_empty && !w_redir;

  // Head outputs: queue head first, then bypass, otherwise an idle NOP.
  always_comb begin
    w_valid = 1'b0;
    w_pc    = '0;
    w_ir    = NOP_INSN;
    if (!w_empty) begin
      w_valid = 1'b1;
      w_pc    = r_pc_mem[r_rd_ptr];
      w_ir    = r_ir_mem[r_rd_ptr];
    end else if (w_byp_live) begin
      w_valid = 1'b1;
      w_pc    = r_fpc;
      w_ir    = w_imem_data;
    end
  end

  // Fetch PC, pointers, occupancy and halt flag; redirect overrides all.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_fpc    <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_halted <= 1'b0;
    end else if (w_ce) begin
      if (w_redir) begin
        r_fpc    <= {w_redir_pc[31:2], 2'b00};
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_halted <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_deq_q) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        if (w_push && !w_deq_q) begin
          r_count <= r_count + CW'(1);
        end else if (!w_push && w_deq_q) begin
          r_count <= r_count - CW'(1);
        end
        if (w_fetch) begin
          r_fpc <= r_fpc + 32'd4;
        end
        if (w_halt_hit) begin
          r_halted <= 1'b1;
        end
      end
    end
  end

  // Queue storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge w_clk) begin
    if (w_ce && w_push) begin
      r_pc_mem[r_wr_ptr] <= r_fpc;
      r_ir_mem[r_wr_ptr] <= w_imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of the fetch front end.
module tb_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam int          AW       = 12;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
  localparam logic [31:0] HALT_INSN = 32'h000f_0033;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   w_clk;
  logic                   w_rst_n;
  logic                   w_ce;
  logic [AW-1:0]          w_imem_addr;
  logic [31:0]            w_imem_data;
  logic                   w_redir;
  logic [31:0]            w_redir_pc;
  logic                   w_deq;
  logic                   w_valid;
  logic [31:0]            w_pc;
  logic [31:0]            w_ir;
  logic                   w_halted;
  logic [$clog2(DEPTH):0] w_count;

  logic [31:0] mem [0:(1<<AW)-1];

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  logic [31:0] m_fpc;
  bit          m_halted;
  logic [31:0] q_pc [$];
  logic [31:0] q_ir [$];

  fetch_buffer #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
    .w_clk       (w_clk),
    .w_rst_n     (w_rst_n),
    .w_ce        (w_ce),
    .w_imem_addr (w_imem_addr),
    .w_imem_data (w_imem_data),
    .w_redir     (w_redir),
    .w_redir_pc  (w_redir_pc),
    .w_deq       (w_deq),
    .w_valid     (w_valid),
    .w_pc        (w_pc),
    .w_ir        (w_ir),
    .w_halted    (w_halted),
    .w_count     (w_count)
  );

  assign w_imem_data = mem[w_imem_addr];

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  function automatic logic [31:0] mem_at(input logic [31:0] pc);
    logic [AW-1:0] a;
    a = pc[AW+1:2];
    return mem[a];
  endfunction

  task automatic model_reset();
    q_pc.delete();
    q_ir.delete();
    m_fpc    = RESET_PC;
    m_halted = 1'b0;
  endtask

  // One enabled clock edge of the fetch front end, from the input rules.
  task automatic model_edge();
    int          sz;
    bit          enq;
    logic [31:0] ins;
    if (!w_ce) return;
    if (w_redir) begin
      q_pc.delete();
      q_ir.delete();
      m_fpc    = {w_redir_pc[31:2], 2'b00};
      m_halted = 1'b0;
      return;
    end
    sz  = q_pc.size();
    ins = mem_at(m_fpc);
    enq = !m_halted && (sz < DEPTH || w_deq);
    if (w_deq && sz > 0) begin
      void'(q_pc.pop_front());
      void'(q_ir.pop_front());
    end
    if (enq) begin
      if (!(BYP && sz == 0 && w_deq)) begin
        q_pc.push_back(m_fpc);
        q_ir.push_back(ins);
      end
      if (ins == HALT_INSN) m_halted = 1'b1;
      m_fpc = m_fpc + 32'd4;
    end
  endtask

  task automatic model_head(output bit v, output logic [31:0] p, output logic [31:0] i);
    v = 1'b0; p = '0; i = NOP_INSN;
    if (q_pc.size() > 0) begin
      v = 1'b1; p = q_pc[0]; i = q_ir[0];
    end else if (BYP && !m_halted && !w_redir) begin
      v = 1'b1; p = m_fpc; i = mem_at(m_fpc);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge w_clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h100 + i;
  endtask

  task automatic do_reset();
    w_ce = 1'b1; w_redir = 1'b0; w_redir_pc = '0; w_deq = 1'b0;
    w_rst_n = 1'b0;
    #2;
    @(posedge w_clk);
    #1;
    w_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    load_ramp();
    do_reset();
    n_total++; if (w_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", w_count); end
    n_total++; if (w_halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got=%b exp=0", w_halted); end
    n_total++; if (w_imem_addr !== RESET_PC[AW+1:2]) begin n_bad++; $display("FAIL reset_addr got=%h exp=%h", w_imem_addr, RESET_PC[AW+1:2]); end
    n_total++; if (w_valid !== BYP) begin n_bad++; $display("FAIL reset_valid got=%b exp=%b", w_valid, BYP); end
    n_total++; if (w_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=0", w_pc); end
    n_total++; if (w_ir !== (BYP ? 32'h100 : NOP_INSN)) begin n_bad++; $display("FAIL reset_ir got=%h exp=%h", w_ir, BYP ? 32'h100 : NOP_INSN); end
  endtask

  task automatic test_stream();
    bit          ev;
    logic [31:0] ep, ei;
    int          ec;
    load_ramp();
    do_reset();
    w_deq = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (BYP) begin
        ev = 1'b1; ep = 4 * k; ei = 32'h100 + k; ec = 0;
      end else begin
        ev = (k >= 1); ep = (k >= 1) ? 4 * (k - 1) : 0;
        ei = (k >= 1) ? 32'h100 + k - 1 : NOP_INSN; ec = (k >= 1) ? 1 : 0;
      end
      n_total++; if (w_valid !== ev) begin n_bad++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, w_valid, ev); end
      n_total++; if (w_pc !== ep) begin n_bad++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, w_pc, ep); end
      n_total++; if (w_ir !== ei) begin n_bad++; $display("FAIL stream_ir k=%0d got=%h exp=%h", k, w_ir, ei); end
      n_total++; if (int'(w_count) != ec) begin n_bad++; $display("FAIL stream_count k=%0d got=%0d exp=%0d", k, w_count, ec); end
      step();
    end
    w_deq = 1'b0;
  endtask

  task automatic test_fill_drain();
    int ek;
    load_ramp();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step();
      ek = (k < DEPTH) ? k : DEPTH;
      n_total++; if (int'(w_count) != ek) begin n_bad++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, w_count, ek); end
      n_total++; if (int'(w_imem_addr) != ek) begin n_bad++; $display("FAIL fill_addr k=%0d got=%0d exp=%0d", k, w_imem_addr, ek); end
    end
    w_deq = 1'b1;
    for (int j = 0; j < 6; j++) begin
      n_total++; if (w_pc !== 32'(4 * j) || w_ir !== 32'(32'h100 + j)) begin n_bad++; $display("FAIL drain_head j=%0d got=%h/%h exp=%h/%h", j, w_pc, w_ir, 4 * j, 32'h100 + j); end
      n_total++; if (int'(w_count) != DEPTH) begin n_bad++; $display("FAIL drain_count j=%0d got=%0d exp=%0d", j, w_count, DEPTH); end
      step();
    end
    w_deq = 1'b0;
  endtask

  task automatic test_redirect();
    load_ramp();
    do_reset();
    step(); step(); step();
    n_total++; if (w_count !== 3'd3) begin n_bad++; $display("FAIL redir_pre_count got=%0d exp=3", w_count); end
    w_redir = 1'b1; w_redir_pc = 32'h203; w_deq = 1'b1;
    step();
    w_redir = 1'b0; w_deq = 1'b0;
    n_total++; if (w_count !== 3'd0) begin n_bad++; $display("FAIL redir_count got=%0d exp=0", w_count); end
    n_total++; if (w_imem_addr !== 12'h080) begin n_bad++; $display("FAIL redir_addr got=%h exp=080", w_imem_addr); end
    n_total++; if (w_valid !== BYP) begin n_bad++; $display("FAIL redir_valid got=%b exp=%b", w_valid, BYP); end
    n_total++; if (w_ir !== (BYP ? 32'h180 : NOP_INSN)) begin n_bad++; $display("FAIL redir_ir got=%h exp=%h", w_ir, BYP ? 32'h180 : NOP_INSN); end
    step();
    n_total++; if (w_pc !== 32'h200 || w_valid !== 1'b1 || w_ir !== 32'h180) begin n_bad++; $display("FAIL redir_target got=%b/%h/%h exp=1/200/180", w_valid, w_pc, w_ir); end
    n_total++; if (w_count !== 3'd1) begin n_bad++; $display("FAIL redir_target_count got=%0d exp=1", w_count); end
  endtask

  task automatic test_halt();
    load_ramp();
    mem[3] = HALT_INSN;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      n_total++; if (w_halted !== 1'b0) begin n_bad++; $display("FAIL halt_early k=%0d got=%b exp=0", k, w_halted); end
      step();
    end
    n_total++; if (w_halted !== 1'b1 || w_count !== 3'd4) begin n_bad++; $display("FAIL halt_set got=%b/%0d exp=1/4", w_halted, w_count); end
    step(); step(); step();
    n_total++; if (w_imem_addr !== 12'd4 || w_count !== 3'd4) begin n_bad++; $display("FAIL halt_hold got=%0d/%0d exp=4/4", w_imem_addr, w_count); end
    w_deq = 1'b1;
    step(); step(); step();
    w_deq = 1'b0;
    n_total++; if (w_count !== 3'd1 || w_ir !== HALT_INSN || w_pc !== 32'hC) begin n_bad++; $display("FAIL halt_drain got=%0d/%h/%h exp=1/000f0033/c", w_count, w_ir, w_pc); end
    n_total++; if (w_imem_addr !== 12'd4 || w_halted !== 1'b1) begin n_bad++; $display("FAIL halt_stop got=%0d/%b exp=4/1", w_imem_addr, w_halted); end
    w_redir = 1'b1; w_redir_pc = 32'h0;
    step();
    w_redir = 1'b0;
    n_total++; if (w_halted !== 1'b0 || w_count !== 3'd0 || w_imem_addr !== 12'd0) begin n_bad++; $display("FAIL halt_redir got=%b/%0d/%0d exp=0/0/0", w_halted, w_count, w_imem_addr); end
    step();
    n_total++; if (w_count !== 3'd1 || w_pc !== 32'h0 || w_ir !== 32'h100) begin n_bad++; $display("FAIL halt_resume got=%0d/%h/%h exp=1/0/100", w_count, w_pc, w_ir); end
    mem[3] = 32'h103;
  endtask

  task automatic test_async_reset();
    load_ramp();
    mem[3] = HALT_INSN;
    do_reset();
    for (int k = 0; k < 6; k++) step();
    n_total++; if (w_count !== 3'd4 || w_halted !== 1'b1) begin n_bad++; $display("FAIL arst_pre got=%0d/%b exp=4/1", w_count, w_halted); end
    #3;
    w_rst_n = 1'b0;
    #1;
    n_total++; if (w_count !== 3'd0) begin n_bad++; $display("FAIL arst_count got=%0d exp=0", w_count); end
    n_total++; if (w_halted !== 1'b0) begin n_bad++; $display("FAIL arst_halted got=%b exp=0", w_halted); end
    n_total++; if (w_valid !== BYP || w_pc !== 32'h0) begin n_bad++; $display("FAIL arst_head got=%b/%h exp=%b/0", w_valid, w_pc, BYP); end
    n_total++; if (w_imem_addr !== RESET_PC[AW+1:2]) begin n_bad++; $display("FAIL arst_addr got=%h exp=%h", w_imem_addr, RESET_PC[AW+1:2]); end
    @(posedge w_clk);
    #1;
    w_rst_n = 1'b1;
    model_reset();
    mem[3] = 32'h103;
  endtask

  task automatic test_random();
    bit          ev;
    logic [31:0] ep, ei;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 15) == 0) mem[i] = HALT_INSN;
    end
    do_reset();
    for (int c = 0; c < 600; c++) begin
      w_ce    = ($urandom_range(0, 99) < 85);
      w_deq   = $urandom_range(0, 1);
      w_redir = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 9) == 0) w_redir_pc = {30'h3FFF_FFFE, 2'($urandom_range(0, 3))};
      else w_redir_pc = $urandom_range(0, 1023);
      step();
      w_redir = 1'b0;
      model_head(ev, ep, ei);
      n_total++;
      if ({w_valid, w_pc, w_ir, w_halted, int'(w_count), w_imem_addr} !==
          {ev, ep, ei, m_halted, q_pc.size(), m_fpc[AW+1:2]}) begin
        n_bad++;
        $display("FAIL random c=%0d got v=%b pc=%h ir=%h h=%b n=%0d a=%h exp v=%b pc=%h ir=%h h=%b n=%0d a=%h",
                 c, w_valid, w_pc, w_ir, w_halted, w_count, w_imem_addr,
                 ev, ep, ei, m_halted, q_pc.size(), m_fpc[AW+1:2]);
      end
    end
    w_ce = 1'b1; w_deq = 1'b0;
  endtask

  initial begin
    w_rst_n = 1'b0; w_ce = 1'b1; w_redir = 1'b0; w_redir_pc = '0; w_deq = 1'b0;
    load_ramp();
    model_reset();
    test_reset();
    test_stream();
    test_fill_drain();
    test_redirect();
    test_halt();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
